// File: rtl/pong_pkg.sv
// pong_pkg: screen size, paddle/ball geometry and game-state type shared by the pong controller and VGA renderer
package pong_pkg;
  localparam int SCREEN_WIDTH = 400;
  localparam int SCREEN_HEIGHT = 600;
  localparam int WRES_BITS = $clog2(SCREEN_WIDTH);
  localparam int HRES_BITS = $clog2(SCREEN_HEIGHT);
  localparam int PADDLE_W = 8;
  localparam int PADDLE_H = 80;
  localparam int PADDLE_MARGIN = 16;
  localparam int BALL_SIZE = 8;
  localparam int PADDLE_STEP = 6;
  localparam int BALL_DX = 3;
  localparam int BALL_DY = 3;
  localparam int SERVE_FRAMES = 60;
  localparam int WIN_SCORE = 7;
  typedef logic [WRES_BITS-1:0] xpos_t;
  typedef logic [HRES_BITS-1:0] ypos_t;
  localparam xpos_t PL_XMIN = xpos_t'(PADDLE_MARGIN);
  localparam xpos_t PL_XMAX = xpos_t'(PADDLE_MARGIN + PADDLE_W - 1);
  localparam xpos_t PR_XMIN = xpos_t'(SCREEN_WIDTH - PADDLE_MARGIN - PADDLE_W);
  localparam xpos_t PR_XMAX = xpos_t'(SCREEN_WIDTH - PADDLE_MARGIN - 1);
  localparam xpos_t BALL_X0 = xpos_t'((SCREEN_WIDTH - BALL_SIZE) / 2);
  localparam ypos_t BALL_Y0 = ypos_t'((SCREEN_HEIGHT - BALL_SIZE) / 2);
  localparam ypos_t BALL_YLIM = ypos_t'(SCREEN_HEIGHT - BALL_SIZE);
  localparam ypos_t PADDLE_Y0 = ypos_t'((SCREEN_HEIGHT - PADDLE_H) / 2);
  localparam ypos_t PADDLE_YLIM = ypos_t'(SCREEN_HEIGHT - PADDLE_H);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} game_state_t;
endpackage

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: frame/button inputs and paddle/ball/score outputs of the pong controller
// Modports: slave = controller side, master = driver/observer side
interface pong_game_ctrl_if;
  import pong_pkg::*;
  logic frame_tick, start, left_up, left_down, right_up, right_down;
  xpos_t paddleleft_xmin, paddleleft_xmax, paddleright_xmin, paddleright_xmax, ball_xmin, ball_xmax;
  ypos_t paddleleft_ymin, paddleleft_ymax, paddleright_ymin, paddleright_ymax, ball_ymin, ball_ymax;
  logic [3:0] score_left, score_right;
  logic game_over;
  modport slave (
    input frame_tick, start, left_up, left_down, right_up, right_down,
    output paddleleft_xmin, paddleleft_xmax, paddleright_xmin, paddleright_xmax, ball_xmin, ball_xmax,
    output paddleleft_ymin, paddleleft_ymax, paddleright_ymin, paddleright_ymax, ball_ymin, ball_ymax,
    output score_left, score_right, game_over
  );
  modport master (
    output frame_tick, start, left_up, left_down, right_up, right_down,
    input paddleleft_xmin, paddleleft_xmax, paddleright_xmin, paddleright_xmax, ball_xmin, ball_xmax,
    input paddleleft_ymin, paddleleft_ymax, paddleright_ymin, paddleright_ymax, ball_ymin, ball_ymax,
    input score_left, score_right, game_over
  );
endinterface

// File: rtl/pong_paddle_step.sv
// pong_paddle_step: next paddle ymin from up/down requests, saturating at the top and bottom of the screen
// Ports: ymin (current), up, down (both or neither = hold), ymin_next
module pong_paddle_step
  import pong_pkg::*;
(
  input  ypos_t ymin,
  input  logic  up,
  input  logic  down,
  output ypos_t ymin_next
);
  logic [HRES_BITS:0] dec, inc;
  always_comb begin
    dec = {1'b0, ymin} - (HRES_BITS + 1)'(PADDLE_STEP);
    inc = {1'b0, ymin} + (HRES_BITS + 1)'(PADDLE_STEP);
    ymin_next = (up && !down) ? (dec[HRES_BITS] ? '0 : dec[HRES_BITS-1:0])
              : (down && !up) ? (inc > {1'b0, PADDLE_YLIM} ? PADDLE_YLIM : inc[HRES_BITS-1:0])
              : ymin;
  end
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: per-frame pong sequencer - paddles, ball motion/collisions, score and serve/play/over FSM
// Ports: clk, rst (sync, active-high); bus (slave): frame_tick/start/buttons in, paddle/ball boxes, scores, game_over out
// Build option: PONG_AI_PADDLE_EN makes the right paddle chase the ball and ignore right_up/right_down
// Pipeline after an accepted frame_tick: paddles, then ball (against new paddles), then state/score
module pong_game_ctrl
  import pong_pkg::*;
(
  input logic clk,
  input logic rst,
  pong_game_ctrl_if.slave bus
);
  localparam int XW = WRES_BITS + 1;
  localparam int YW = HRES_BITS + 1;
  game_state_t state, state_next;
  ypos_t pl_y, pr_y, pl_y_next, pr_y_next, by, by_next, ny;
  xpos_t bx, bx_next;
  logic dir_r, dir_d, dir_r_next, dir_d_next, ny_d;
  logic [3:0] score_l, score_r, score_l_next, score_r_next;
  logic [5:0] serve_cnt, serve_cnt_next;
  logic s1, s2, go, start_q, pt_l, pt_r, pt_l_next, pt_r_next;
  logic move, play, hit, miss, ctr, pr_up, pr_down, ny_ovf, hit_l, hit_r;
  logic [XW-1:0] nxl, nxr;
  logic [YW-1:0] nyu, nyd;
  assign go = bus.frame_tick && !s1 && !s2;
  assign move = state == SERVE || state == PLAY;
  assign play = state == PLAY;
`ifdef PONG_AI_PADDLE_EN
  logic [YW-1:0] ball_c, pad_c;
  assign ball_c = {1'b0, by} + YW'(BALL_SIZE / 2);
  assign pad_c = {1'b0, pr_y} + YW'(PADDLE_H / 2);
  assign pr_up = ball_c < pad_c;
  assign pr_down = ball_c > pad_c;
`else
  assign pr_up = bus.right_up;
  assign pr_down = bus.right_down;
`endif
  pong_paddle_step u_left (
    .ymin(pl_y), .up(move && bus.left_up), .down(move && bus.left_down), .ymin_next(pl_y_next)
  );
  pong_paddle_step u_right (
    .ymin(pr_y), .up(move && pr_up), .down(move && pr_down), .ymin_next(pr_y_next)
  );
  // Ball step; extra top bit on every sum exposes under/overflow before clamping
  always_comb begin
    nxl = {1'b0, bx} - XW'(BALL_DX);
    nxr = {1'b0, bx} + XW'(BALL_DX);
    nyu = {1'b0, by} - YW'(BALL_DY);
    nyd = {1'b0, by} + YW'(BALL_DY);
    ny_ovf = nyd > {1'b0, BALL_YLIM};
    ny = dir_d ? (ny_ovf ? BALL_YLIM : nyd[HRES_BITS-1:0]) : (nyu[HRES_BITS] ? '0 : nyu[HRES_BITS-1:0]);
    ny_d = dir_d ? !ny_ovf : nyu[HRES_BITS];
    hit_l = nxl <= {1'b0, PL_XMAX} && nxl + XW'(BALL_SIZE - 1) >= {1'b0, PL_XMIN}
         && {1'b0, ny} + YW'(BALL_SIZE - 1) >= {1'b0, pl_y} && {1'b0, ny} <= {1'b0, pl_y} + YW'(PADDLE_H - 1);
    hit_r = nxr <= {1'b0, PR_XMAX} && nxr + XW'(BALL_SIZE - 1) >= {1'b0, PR_XMIN}
         && {1'b0, ny} + YW'(BALL_SIZE - 1) >= {1'b0, pr_y} && {1'b0, ny} <= {1'b0, pr_y} + YW'(PADDLE_H - 1);
    hit = dir_r ? hit_r : hit_l;
    miss = dir_r ? nxr + XW'(BALL_SIZE - 1) > XW'(SCREEN_WIDTH - 1) : bx < xpos_t'(BALL_DX);
    ctr = state == IDLE || state == SERVE || (play && !hit && miss);
    bx_next = ctr ? BALL_X0 : !play ? bx
            : hit ? (dir_r ? PR_XMIN - xpos_t'(BALL_SIZE) : PL_XMAX + xpos_t'(1))
            : dir_r ? nxr[WRES_BITS-1:0] : nxl[WRES_BITS-1:0];
    by_next = ctr ? BALL_Y0 : play ? ny : by;
    dir_r_next = (play && hit) ? !dir_r : dir_r;
    dir_d_next = (play && !ctr) ? ny_d : dir_d;
    pt_l_next = play && dir_r && !hit && miss;
    pt_r_next = play && !dir_r && !hit && miss;
  end
  always_comb begin
    state_next = state;
    score_l_next = score_l;
    score_r_next = score_r;
    serve_cnt_next = serve_cnt;
    unique case (state)
      IDLE, OVER: if (start_q) begin
        state_next = SERVE;
        score_l_next = '0;
        score_r_next = '0;
        serve_cnt_next = '0;
      end
      SERVE: begin
        state_next = serve_cnt == 6'(SERVE_FRAMES - 1) ? PLAY : SERVE;
        serve_cnt_next = serve_cnt == 6'(SERVE_FRAMES - 1) ? '0 : serve_cnt + 6'd1;
      end
      PLAY: begin
        score_l_next = score_l + 4'(pt_l);
        score_r_next = score_r + 4'(pt_r);
        state_next = (score_l_next == 4'(WIN_SCORE) || score_r_next == 4'(WIN_SCORE)) ? OVER
                   : (pt_l || pt_r) ? SERVE : PLAY;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      {s1, s2, start_q, pt_l, pt_r} <= '0;
      pl_y <= PADDLE_Y0;
      pr_y <= PADDLE_Y0;
      bx <= BALL_X0;
      by <= BALL_Y0;
      dir_r <= 1'b1;
      dir_d <= 1'b1;
      state <= IDLE;
      score_l <= '0;
      score_r <= '0;
      serve_cnt <= '0;
    end else begin
      s1 <= go;
      s2 <= s1;
      if (go) begin
        pl_y <= pl_y_next;
        pr_y <= pr_y_next;
        start_q <= bus.start;
      end
      if (s1) begin
        bx <= bx_next;
        by <= by_next;
        dir_r <= dir_r_next;
        dir_d <= dir_d_next;
        pt_l <= pt_l_next;
        pt_r <= pt_r_next;
      end
      if (s2) begin
        state <= state_next;
        score_l <= score_l_next;
        score_r <= score_r_next;
        serve_cnt <= serve_cnt_next;
      end
    end
  assign bus.paddleleft_xmin = PL_XMIN;
  assign bus.paddleleft_xmax = PL_XMAX;
  assign bus.paddleright_xmin = PR_XMIN;
  assign bus.paddleright_xmax = PR_XMAX;
  assign bus.paddleleft_ymin = pl_y;
  assign bus.paddleleft_ymax = pl_y + ypos_t'(PADDLE_H - 1);
  assign bus.paddleright_ymin = pr_y;
  assign bus.paddleright_ymax = pr_y + ypos_t'(PADDLE_H - 1);
  assign bus.ball_xmin = bx;
  assign bus.ball_xmax = bx + xpos_t'(BALL_SIZE - 1);
  assign bus.ball_ymin = by;
  assign bus.ball_ymax = by + ypos_t'(BALL_SIZE - 1);
  assign bus.score_left = score_l;
  assign bus.score_right = score_r;
  assign bus.game_over = state == OVER;
endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Frame-rate game sequencer for the pong design. Once per video frame it updates paddle positions from player buttons, advances the ball, resolves wall and paddle collisions, keeps score and runs the serve/play/game-over state machine. Its bounding-box outputs feed the VGA renderer's paddle and ball inputs directly. All updates complete within a few cycles after the frame tick, so they land inside vertical blanking.

## Interface
- SCREEN_WIDTH, 400, playfield width in pixels
- SCREEN_HEIGHT, 600, playfield height in lines
- PADDLE_W, 8, paddle width
- PADDLE_H, 80, paddle height
- PADDLE_MARGIN, 16, gap from screen edge to paddle
- BALL_SIZE, 8, ball side length
- PADDLE_STEP, 6, paddle pixels per frame
- BALL_DX / BALL_DY, 3 / 3, ball pixels per frame per axis
- SERVE_FRAMES, 60, frames the ball is held before a serve
- WIN_SCORE, 7, points that end the game
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse, start of vertical blank
- start  in  1  level, debounced; begins or restarts a game
- left_up, left_down, right_up, right_down  in  1 each  debounced player buttons
- paddleleft_xmin/xmax, paddleright_xmin/xmax, ball_xmin/xmax  out  WRES_BITS ($clog2(SCREEN_WIDTH)=9)  inclusive x bounds
- paddleleft_ymin/ymax, paddleright_ymin/ymax, ball_ymin/ymax  out  HRES_BITS ($clog2(SCREEN_HEIGHT)=10)  inclusive y bounds
- score_left, score_right  out  4  points
- game_over  out  1  high in OVER state

## Operation
- States: IDLE, SERVE, PLAY, OVER. Reset puts the block in IDLE.
- IDLE: hold the ball at centre. `start` high at a frame tick clears the scores and moves to SERVE.
- SERVE: hold the ball at centre and count SERVE_FRAMES ticks, then move to PLAY. Paddles move in SERVE and PLAY only.
- PLAY to SERVE on a miss: increment the scorer's score. The next serve goes toward the player who conceded.
- PLAY to OVER when the incremented score equals WIN_SCORE. OVER holds all positions. `start` at a frame tick clears the scores and moves to SERVE.
- Paddle move rules:
  - Up only: ymin -= PADDLE_STEP, saturating at 0.
  - Down only: ymin += PADDLE_STEP, saturating at SCREEN_HEIGHT-PADDLE_H (520).
  - Both or neither pressed: hold.
  - ymax = ymin+PADDLE_H-1 always.
- Fixed x bounds:
  - Left paddle: 16..23.
  - Right paddle: 376..383.
- Centre positions:
  - Paddle y: 260..339.
  - Ball: x 196..203, y 296..303.
- Ball vertical motion:
  - Move by BALL_DY in direction dir_y.
  - If the next ymin would be <0, clamp to 0 and set dir_y down.
  - If the next ymin would be >592, clamp to 592 and set dir_y up.
- Ball horizontal motion, moving left (the right-moving case mirrors it):
  - If the next ball box overlaps the left paddle in x, and y overlaps the updated paddle, set xmin=24 and dir_x=right.
  - Else, if xmin < BALL_DX, the right player scores.
- Initial serve direction is dir_x right, dir_y down. dir_y is kept across serves.
- All arithmetic uses one extra bit of width so that underflow and overflow can be detected before clamping.

## Timing
- frame_tick at cycle T:
  - T+1: paddle registers updated.
  - T+2: ball position and direction updated, with collisions resolved against the T+1 paddles.
  - T+3: state, score and game_over updated.
- Outputs are registered and are stable except on those cycles.
- frame_tick while a sequence is in progress is ignored.
- `start` is sampled only on frame_tick cycles.
- rst mid-sequence aborts it. The next cycle shows reset values:
  - Paddles and ball centred.
  - Scores 0, game_over 0, state IDLE.
  - Serve counter 0.

## Configuration
- PONG_AI_PADDLE_EN defined: right_up and right_down are ignored. Each frame the right paddle moves PADDLE_STEP toward the ball centre:
  - Up if ball_ymin+BALL_SIZE/2 < paddle ymin+PADDLE_H/2.
  - Down if greater.
  - Hold if equal.
  - Saturation rules are the same as for player paddles.
- PONG_AI_PADDLE_EN undefined: both paddles are button-driven.

## Structure
- Shared package pong_pkg holds:
  - Screen size constants and WRES_BITS/HRES_BITS.
  - Paddle and ball geometry constants.
  - The game-state enum.
- These constants are common with the VGA renderer.
- One sub-module, pong_paddle_step: a saturating up/down position update, instantiated twice. The AI direction logic sits outside it.

## Test plan
- Reset, then 2 frame ticks with no input -> outputs at centre values, scores 0, state IDLE, game_over 0.
- Start, then left_up held for 50 ticks -> left ymin steps 260,254,… and saturates at 0, ymax=79. Both buttons held -> no motion.
- PLAY with ball forced to ymin 590, dir_y down -> next frame ymin=592 and dir_y up. The following frame ymin=589.
- Left paddle at 260..339, ball at xmin 26 moving left, y 300 -> ball xmin=24 and dir_x right at T+2.
- Ball moving right, right paddle away from it -> score_left increments at T+3, state SERVE, ball centred, serve toward the right player after 60 ticks.
- score_left=6 and a further miss -> score_left=7, game_over=1. Start at the next tick -> scores 0, state SERVE.
- With PONG_AI_PADDLE_EN: ball at y 100, right paddle centred -> right ymin decreases by 6 per frame.
